// File: rtl/wb_stage.sv
// Writeback stage: waits for load data when needed, aligns and extends it, and
// issues one registered register-file write per completed instruction.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | accepting bundles; writes issue the cycle after accept
// WAIT_MEM | load latched, waiting for dmem_rvalid to complete it
module wb_stage #(
  parameter int WORD_SIZE = 32,
  parameter int NUM_REGS  = 32,
  parameter int REG_SEL   = $clog2(NUM_REGS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [REG_SEL-1:0]   in_rd,
  input  logic [WORD_SIZE-1:0] in_alu_result,
  input  logic                 in_mem_to_reg,
  input  logic                 in_reg_write,
  input  logic [1:0]           in_data_size,
  input  logic                 in_data_sign,
  input  logic [1:0]           in_addr_lo,
  input  logic                 dmem_rvalid,
  input  logic [WORD_SIZE-1:0] dmem_rdata,
  output logic                 reg_write,
  output logic [REG_SEL-1:0]   rd_select,
  output logic [WORD_SIZE-1:0] rd_data
);

  typedef enum logic {IDLE = 1'b0, WAIT_MEM = 1'b1} state_t;

  state_t               state, state_nxt;
  logic [REG_SEL-1:0]   lat_rd;
  logic                 lat_wr;
  logic [1:0]           lat_size;
  logic                 lat_sign;
  logic [1:0]           lat_addr;

  logic                 accept;
  logic                 load_park;
  logic                 issue;
  logic                 we_nxt;
  logic [REG_SEL-1:0]   sel_rd;
  logic                 sel_wr;
  logic                 sel_load;
  logic [1:0]           sel_size;
  logic                 sel_sign;
  logic [1:0]           sel_addr;
  logic [WORD_SIZE-1:0] wdata_nxt;

  function automatic logic [WORD_SIZE-1:0] extract(
    input logic [WORD_SIZE-1:0] rdata,
    input logic [1:0]           size,
    input logic                 sign,
    input logic [1:0]           addr
  );
    logic [7:0]           b;
    logic [15:0]          h;
    logic [WORD_SIZE-1:0] r;
    case (addr)
      2'd0:    b = rdata[7:0];
      2'd1:    b = rdata[15:8];
      2'd2:    b = rdata[23:16];
      default: b = rdata[31:24];
    endcase
    // half-word misalignment is not detected; addr[0] is simply ignored
    h = addr[1] ? rdata[31:16] : rdata[15:0];
    case (size)
      2'b00:   r = {{(WORD_SIZE-8){sign & b[7]}}, b};
      2'b01:   r = {{(WORD_SIZE-16){sign & h[15]}}, h};
      default: r = rdata;
    endcase
    return r;
  endfunction

  assign in_ready  = (state == IDLE);
  assign accept    = in_valid && in_ready;
  assign load_park = accept && in_mem_to_reg && !dmem_rvalid;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      lat_rd   <= '0;
      lat_wr   <= 1'b0;
      lat_size <= 2'b00;
      lat_sign <= 1'b0;
      lat_addr <= 2'b00;
    end else begin
      state <= state_nxt;
      if (load_park) begin
        lat_rd   <= in_rd;
        lat_wr   <= in_reg_write;
        lat_size <= in_data_size;
        lat_sign <= in_data_sign;
        lat_addr <= in_addr_lo;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (load_park) state_nxt = WAIT_MEM;
      WAIT_MEM: if (dmem_rvalid) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_comb begin
    issue    = 1'b0;
    sel_rd   = in_rd;
    sel_wr   = in_reg_write;
    sel_load = in_mem_to_reg;
    sel_size = in_data_size;
    sel_sign = in_data_sign;
    sel_addr = in_addr_lo;
    if (state == WAIT_MEM) begin
      issue    = dmem_rvalid;
      sel_rd   = lat_rd;
      sel_wr   = lat_wr;
      sel_load = 1'b1;
      sel_size = lat_size;
      sel_sign = lat_sign;
      sel_addr = lat_addr;
    end else begin
      issue = accept && (!in_mem_to_reg || dmem_rvalid);
    end
    we_nxt    = issue && sel_wr && (sel_rd != '0);
    wdata_nxt = sel_load ? extract(dmem_rdata, sel_size, sel_sign, sel_addr)
                         : in_alu_result;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      reg_write <= 1'b0;
      rd_select <= '0;
      rd_data   <= '0;
    end else begin
      reg_write <= we_nxt;
      if (we_nxt) begin
        rd_select <= sel_rd;
        rd_data   <= wdata_nxt;
      end
    end
  end

endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage: vector table for single-cycle writebacks plus
// hand sequences for delayed loads and reset during a pending load.
module tb_wb_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_rd;
  logic [31:0] in_alu_result;
  logic        in_mem_to_reg;
  logic        in_reg_write;
  logic [1:0]  in_data_size;
  logic        in_data_sign;
  logic [1:0]  in_addr_lo;
  logic        dmem_rvalid;
  logic [31:0] dmem_rdata;
  logic        reg_write;
  logic [4:0]  rd_select;
  logic [31:0] rd_data;

  int n_checks = 0;
  int n_pass   = 0;

  wb_stage dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_rd(in_rd), .in_alu_result(in_alu_result),
    .in_mem_to_reg(in_mem_to_reg), .in_reg_write(in_reg_write),
    .in_data_size(in_data_size), .in_data_sign(in_data_sign),
    .in_addr_lo(in_addr_lo),
    .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
    .reg_write(reg_write), .rd_select(rd_select), .rd_data(rd_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        valid;
    logic [4:0]  rd;
    logic [31:0] alu;
    logic        m2r;
    logic        wr;
    logic [1:0]  size;
    logic        sign;
    logic [1:0]  addr;
    logic        rvalid;
    logic [31:0] rdata;
    logic        e_we;
    logic [4:0]  e_sel;
    logic [31:0] e_data;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(string name, logic valid, logic [4:0] rd, logic [31:0] alu,
                              logic m2r, logic wr, logic [1:0] size, logic sign,
                              logic [1:0] addr, logic rvalid, logic [31:0] rdata,
                              logic e_we, logic [4:0] e_sel, logic [31:0] e_data);
    vec_t v;
    v.name = name; v.valid = valid; v.rd = rd; v.alu = alu; v.m2r = m2r; v.wr = wr;
    v.size = size; v.sign = sign; v.addr = addr; v.rvalid = rvalid; v.rdata = rdata;
    v.e_we = e_we; v.e_sel = e_sel; v.e_data = e_data;
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  task automatic drive(logic valid, logic [4:0] rd, logic [31:0] alu, logic m2r, logic wr,
                       logic [1:0] size, logic sign, logic [1:0] addr,
                       logic rvalid, logic [31:0] rdata);
    in_valid = valid; in_rd = rd; in_alu_result = alu; in_mem_to_reg = m2r;
    in_reg_write = wr; in_data_size = size; in_data_sign = sign; in_addr_lo = addr;
    dmem_rvalid = rvalid; dmem_rdata = rdata;
  endtask

  task automatic chk_out(string name, logic we, logic [4:0] sel, logic [31:0] data);
    chk({name, ".reg_write"}, {31'd0, reg_write}, {31'd0, we});
    chk({name, ".rd_select"}, {27'd0, rd_select}, {27'd0, sel});
    chk({name, ".rd_data"}, rd_data, data);
  endtask

  initial begin
    rst = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // reset held with toggling inputs
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      drive($urandom_range(0, 1), 5'($urandom), $urandom, $urandom_range(0, 1),
            $urandom_range(0, 1), 2'($urandom), $urandom_range(0, 1), 2'($urandom),
            $urandom_range(0, 1), $urandom);
      @(posedge clk); #1;
      chk_out("reset", 0, 0, 0);
      chk("reset.in_ready", {31'd0, in_ready}, 1);
    end
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b1;

    //              name          v  rd  alu           m2r wr sz  sg ad  rv rdata        we sel data
    vecs.push_back(mk("alu_rd5",   1, 5,  32'hDEADBEEF, 0, 1, 0, 0, 0, 0, 0,            1, 5,  32'hDEADBEEF));
    vecs.push_back(mk("idle",      0, 0,  0,            0, 0, 0, 0, 0, 0, 0,            0, 5,  32'hDEADBEEF));
    vecs.push_back(mk("x0_supp",   1, 0,  32'h00001234, 0, 1, 0, 0, 0, 0, 0,            0, 5,  32'hDEADBEEF));
    vecs.push_back(mk("no_wr",     1, 3,  32'h00000055, 0, 0, 0, 0, 0, 0, 0,            0, 5,  32'hDEADBEEF));
    vecs.push_back(mk("lhu_hi",    1, 9,  0,            1, 1, 1, 0, 2, 1, 32'h8001ABCD, 1, 9,  32'h00008001));
    vecs.push_back(mk("lw",        1, 10, 0,            1, 1, 2, 0, 0, 1, 32'h8001ABCD, 1, 10, 32'h8001ABCD));
    vecs.push_back(mk("lh_lo",     1, 11, 0,            1, 1, 1, 1, 0, 1, 32'h8001ABCD, 1, 11, 32'hFFFFABCD));
    vecs.push_back(mk("lbu_b3",    1, 12, 0,            1, 1, 0, 0, 3, 1, 32'h8001ABCD, 1, 12, 32'h00000080));
    vecs.push_back(mk("lb_b1",     1, 13, 0,            1, 1, 0, 1, 1, 1, 32'h8001ABCD, 1, 13, 32'hFFFFFFAB));
    vecs.push_back(mk("alu_b2b_a", 1, 1,  32'h00000001, 0, 1, 0, 0, 0, 0, 0,            1, 1,  32'h00000001));
    vecs.push_back(mk("alu_b2b_b", 1, 31, 32'hFFFF0000, 0, 1, 0, 0, 0, 0, 0,            1, 31, 32'hFFFF0000));
    vecs.push_back(mk("lw_sz3",    1, 2,  32'hAAAAAAAA, 1, 1, 3, 1, 0, 1, 32'h12345678, 1, 2,  32'h12345678));
    vecs.push_back(mk("stale_rv",  0, 14, 0,            1, 1, 2, 0, 0, 1, 32'h0BADF00D, 0, 2,  32'h12345678));
    vecs.push_back(mk("lhu_a3",    1, 4,  0,            1, 1, 1, 0, 3, 1, 32'h8001ABCD, 1, 4,  32'h00008001));
    vecs.push_back(mk("lb_x0",     1, 0,  0,            1, 1, 0, 1, 0, 1, 32'h000000FF, 0, 4,  32'h00008001));

    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i].valid, vecs[i].rd, vecs[i].alu, vecs[i].m2r, vecs[i].wr,
            vecs[i].size, vecs[i].sign, vecs[i].addr, vecs[i].rvalid, vecs[i].rdata);
      #1 chk({vecs[i].name, ".in_ready"}, {31'd0, in_ready}, 1);
      @(posedge clk); #1;
      chk_out(vecs[i].name, vecs[i].e_we, vecs[i].e_sel, vecs[i].e_data);
    end
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    chk_out("after_table", 0, 4, 32'h00008001);

    // delayed signed byte load; a bundle offered during the wait must be ignored
    @(negedge clk);
    drive(1, 7, 32'h0, 1, 1, 2'b00, 1, 2'd2, 0, 32'h0);
    @(posedge clk); #1;
    chk_out("dly_accept", 0, 4, 32'h00008001);
    chk("dly_accept.in_ready", {31'd0, in_ready}, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      drive(1, 20, 32'hCAFEF00D, 0, 1, 0, 0, 0, 0, 32'h0);
      @(posedge clk); #1;
      chk_out("dly_wait", 0, 4, 32'h00008001);
      chk("dly_wait.in_ready", {31'd0, in_ready}, 0);
    end
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h11F02233);
    #1 chk("dly_resp.in_ready_before", {31'd0, in_ready}, 0);
    @(posedge clk); #1;
    chk_out("dly_resp", 1, 7, 32'hFFFFFFF0);
    chk("dly_resp.in_ready", {31'd0, in_ready}, 1);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    chk_out("dly_pulse_end", 0, 7, 32'hFFFFFFF0);

    // load without reg_write still waits for and consumes its response
    @(negedge clk);
    drive(1, 8, 0, 1, 0, 2'b10, 0, 0, 0, 0);
    @(posedge clk); #1;
    chk("nowr_load.in_ready", {31'd0, in_ready}, 0);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h55555555);
    @(posedge clk); #1;
    chk_out("nowr_resp", 0, 7, 32'hFFFFFFF0);
    chk("nowr_resp.in_ready", {31'd0, in_ready}, 1);

    // reset while waiting abandons the load; a later stale response is ignored
    @(negedge clk);
    drive(1, 6, 0, 1, 1, 2'b10, 0, 0, 0, 0);
    @(posedge clk); #1;
    chk("rstw_enter.in_ready", {31'd0, in_ready}, 0);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b0;
    #1;
    chk_out("rstw_in_reset", 0, 0, 0);
    chk("rstw_in_reset.in_ready", {31'd0, in_ready}, 1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h76543210);
    @(posedge clk); #1;
    chk_out("rstw_stale", 0, 0, 0);
    chk("rstw_stale.in_ready", {31'd0, in_ready}, 1);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    chk_out("rstw_quiet", 0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/wb_stage.md
# wb_stage

Writeback stage. It accepts the completed-instruction bundle from the memory stage, waits for the data-memory read response on loads, and byte/half/word-aligns and sign/zero-extends the load data. It then issues a registered write to the register-file write port: `reg_write`, `rd_select` and `rd_data`. It is the producer for the write-side inputs of the decode stage's register file.

## Interface
- `WORD_SIZE`, 32, datapath width
- `NUM_REGS`, 32, architectural register count
- `REG_SEL`, `$clog2(NUM_REGS)`, register select width

Ports:
- `clk`  in  1  sole clock; all state updates on the rising edge
- `rst`  in  1  asynchronous, active-low reset
- `in_valid`  in  1  memory-stage bundle valid
- `in_ready`  out  1  stage can accept a bundle; equals (state == IDLE)
- `in_rd`  in  REG_SEL  destination register
- `in_alu_result`  in  WORD_SIZE  ALU result, written when not a load
- `in_mem_to_reg`  in  1  instruction is a load
- `in_reg_write`  in  1  instruction writes the register file
- `in_data_size`  in  2  load size: 00 byte, 01 half, 10/11 word
- `in_data_sign`  in  1  1 = sign-extend, 0 = zero-extend
- `in_addr_lo`  in  2  load address bits [1:0]
- `dmem_rvalid`  in  1  data-memory read response valid
- `dmem_rdata`  in  WORD_SIZE  data-memory read word
- `reg_write`  out  1  register-file write enable, one-cycle pulse
- `rd_select`  out  REG_SEL  write register select
- `rd_data`  out  WORD_SIZE  write data

## Operation
- FSM states:
  - IDLE: accepts bundles.
  - WAIT_MEM: holds a latched load and waits for `dmem_rvalid`.
- Accept: `in_valid && in_ready`. The bundle is ignored when `in_ready` is 0.
- Non-load accept (`in_mem_to_reg` = 0): the write is issued using `in_alu_result`. State stays IDLE.
- Load accept with `dmem_rvalid` = 1 in the same cycle: the write is issued using the extracted `dmem_rdata`. State stays IDLE.
- Load accept with `dmem_rvalid` = 0:
  - `in_rd`, `in_reg_write`, size, sign and `in_addr_lo` are latched.
  - State moves to WAIT_MEM.
- WAIT_MEM with `dmem_rvalid` = 1: the write is issued from the latched fields plus the extracted data. State returns to IDLE.
- `dmem_rvalid` while in IDLE with no accepting load: ignored.
- Write issue rule:
  - `reg_write` is 1 only if reg_write (incoming or latched) = 1 and rd ≠ 0. x0 is never written.
  - A load with reg_write = 0 still waits for and consumes its response.
- Extraction from `dmem_rdata`:
  - Byte: `rdata[8*addr_lo +: 8]`.
  - Half: `addr_lo[1]` selects `rdata[31:16]` or `rdata[15:0]`; `addr_lo[0]` is ignored (misalignment is not detected).
  - Word: the full 32 bits.
  - Extension to `WORD_SIZE` is by `data_sign`.
- `rd_select` and `rd_data` update only when a write is issued, and hold otherwise.

## Timing
- All outputs are registered, except `in_ready`, which is decoded combinationally from state.
- Reset (`rst` low, asynchronous):
  - state = IDLE
  - `reg_write` = 0, `rd_select` = 0, `rd_data` = 0
  - `in_ready` = 1
- Non-load latency: accept at edge N gives `reg_write` high during cycle N+1, for exactly one cycle.
- Load latency: `dmem_rvalid` sampled at edge M gives `reg_write` high during cycle M+1.
- `in_ready` is 0 from the edge entering WAIT_MEM until the edge on which `dmem_rvalid` is sampled. A new bundle can be accepted on the cycle after the response.
- Back-to-back non-loads: one write per cycle, with no bubbles.
- Reset asserted while in WAIT_MEM: the pending load is abandoned and no write is issued. A later stale `dmem_rvalid` in IDLE is ignored.
- Throughput: 1 bundle/cycle when loads respond in the same cycle.

## Test plan
- Reset: hold `rst` = 0 with random inputs toggling → `reg_write` = 0, `rd_select` = 0, `rd_data` = 0, `in_ready` = 1 throughout.
- ALU writeback: accept rd = 5, alu = 0xDEADBEEF, reg_write = 1 → next cycle `reg_write` = 1, `rd_select` = 5, `rd_data` = 0xDEADBEEF; the following cycle `reg_write` = 0.
- x0 suppression: accept rd = 0, reg_write = 1, alu = 0x1234 → `reg_write` stays 0 and `rd_select`/`rd_data` are unchanged.
- Delayed signed byte load:
  - Stimulus: accept load rd = 7, size = 00, sign = 1, addr_lo = 2 with rvalid = 0; 3 idle cycles; then rvalid = 1 with rdata = 0x11F02233.
  - Required response: `in_ready` = 0 for those cycles, then `reg_write` = 1, `rd_select` = 7, `rd_data` = 0xFFFFFFF0.
- Unsigned half and word loads, same-cycle rvalid, back-to-back:
  - Half: rdata = 0x8001ABCD, addr_lo = 2, sign = 0 → 0x00008001.
  - Word: then 0x8001ABCD.
  - Consecutive `reg_write` pulses with no stall.
- Reset mid-WAIT_MEM: enter WAIT_MEM, assert `rst`, release, then pulse rvalid = 1 → no write occurs and `in_ready` = 1.
